// File: rtl/branch_sequencer.sv
// PC/branch sequencer: fetches through a req/ack handshake, runs the ALU compare for
// conditional branches, then commits the target or pc+4, trapping on misaligned targets.
module branch_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             fetch_req,
  output logic [XLEN-1:0]  fetch_addr,
  input  logic             fetch_ack,
  input  logic [1:0]       op,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  target,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [3:0]       status,
  output logic [XLEN-1:0]  pc,
  output logic             taken,
  output logic             trap,
  input  logic             trap_clr,
  output logic [CNT_W-1:0] taken_cnt
);

  // ALU flag positions within status.
  localparam int unsigned Z_STATUS = 0;
  localparam int unsigned N_STATUS = 1;
  localparam int unsigned C_STATUS = 2;
  localparam int unsigned V_STATUS = 3;

  localparam logic [1:0] OP_JUMP   = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  // The UPDATE cycle is split by outcome so taken can be decoded from the state alone.
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_CMP_START,
    S_CMP_WAIT,
    S_UPD_SEQ,
    S_UPD_TAKE,
    S_UPD_TRAP,
    S_TRAP
  } state_t;

  state_t           state;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  target_q;

  function automatic logic branch_cond(input logic [2:0] f, input logic [3:0] s);
    logic lt;
    lt = s[N_STATUS] ^ s[V_STATUS];
    case (f)
      3'b000:  return s[Z_STATUS];
      3'b001:  return ~s[Z_STATUS];
      3'b100:  return lt;
      3'b101:  return ~lt;
      3'b110:  return s[C_STATUS];
      3'b111:  return ~s[C_STATUS];
      default: return 1'b0;
    endcase
  endfunction

  function automatic state_t update_state(input logic ld, input logic [XLEN-1:0] tgt);
    if (!ld)                 return S_UPD_SEQ;
    else if (tgt[1:0] != 2'b00) return S_UPD_TRAP;
    else                     return S_UPD_TAKE;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      taken_cnt <= '0;
      trap      <= 1'b0;
      funct3_q  <= '0;
      target_q  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetch_ack) state <= S_DECODE;
        end
        S_DECODE: begin
          funct3_q <= funct3;
          target_q <= target;
          if (op == OP_BRANCH)    state <= S_CMP_START;
          else if (op == OP_JUMP) state <= update_state(1'b1, target);
          else                    state <= S_UPD_SEQ;
        end
        S_CMP_START, S_CMP_WAIT: begin
          if (alu_done) state <= update_state(branch_cond(funct3_q, status), target_q);
          else          state <= S_CMP_WAIT;
        end
        S_UPD_SEQ: begin
          pc    <= pc + XLEN'(4);
          state <= S_FETCH;
        end
        S_UPD_TAKE: begin
          pc <= target_q;
          if (taken_cnt != {CNT_W{1'b1}}) taken_cnt <= taken_cnt + CNT_W'(1);
          state <= S_FETCH;
        end
        S_UPD_TRAP: begin
          trap  <= 1'b1;
          state <= S_TRAP;
        end
        S_TRAP: begin
          if (trap_clr) begin
            trap  <= 1'b0;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign fetch_req  = (state == S_FETCH);
  assign alu_start  = (state == S_CMP_START);
  assign taken      = (state == S_UPD_TAKE);
  assign fetch_addr = pc;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer; a narrow-counter twin shares the stimulus for saturation.
module tb_branch_sequencer;

  localparam int unsigned XLEN = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             fetch_ack = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [2:0]       funct3 = 3'b000;
  logic [XLEN-1:0]  target = '0;
  logic             alu_done = 1'b0;
  logic [3:0]       status = 4'b0000;
  logic             trap_clr = 1'b0;

  logic             fetch_req, alu_start, taken, trap;
  logic [XLEN-1:0]  fetch_addr, pc;
  logic [15:0]      taken_cnt;

  logic             s_fetch_req, s_alu_start, s_taken, s_trap;
  logic [XLEN-1:0]  s_fetch_addr, s_pc;
  logic [2:0]       s_taken_cnt;

  int tests = 0;
  int fails = 0;

  branch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .op(op), .funct3(funct3), .target(target),
    .alu_start(alu_start), .alu_done(alu_done), .status(status), .pc(pc),
    .taken(taken), .trap(trap), .trap_clr(trap_clr), .taken_cnt(taken_cnt)
  );

  branch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr),
    .fetch_ack(fetch_ack), .op(op), .funct3(funct3), .target(target),
    .alu_start(s_alu_start), .alu_done(alu_done), .status(status), .pc(s_pc),
    .taken(s_taken), .trap(s_trap), .trap_clr(trap_clr), .taken_cnt(s_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one instruction; returns with the DUT in DECODE.
  task automatic issue(input logic [1:0] o, input logic [2:0] f, input logic [31:0] t);
    fetch_ack = 1'b1;
    op = o;
    funct3 = f;
    target = t;
    tick();
    fetch_ack = 1'b0;
  endtask

  task automatic nonbranch(input string tag, input logic [1:0] o, input logic [31:0] t,
                           input logic exp_taken, input logic [31:0] exp_pc);
    issue(o, 3'b000, t);
    tick();
    chk({tag, "_taken"}, 32'(taken), 32'(exp_taken));
    tick();
    chk({tag, "_pc"}, pc, exp_pc);
  endtask

  // Branch with alu_done returned in the same cycle as alu_start.
  task automatic branch(input string tag, input logic [2:0] f, input logic [31:0] t,
                        input logic [3:0] st, input logic exp_taken, input logic [31:0] exp_pc);
    issue(2'b10, f, t);
    tick();
    chk({tag, "_alu_start"}, 32'(alu_start), 32'd1);
    alu_done = 1'b1;
    status = st;
    tick();
    alu_done = 1'b0;
    chk({tag, "_taken"}, 32'(taken), 32'(exp_taken));
    tick();
    chk({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_fetch_req", 32'(fetch_req), 32'd1);
    tick();
    tick();
    chk("stall_fetch_addr", fetch_addr, 32'h0);
    chk("stall_fetch_req", 32'(fetch_req), 32'd1);

    // Sequential: pc+4 two cycles after ack
    nonbranch("seq0", 2'b00, 32'h40, 1'b0, 32'h4);

    // Jump to 0x100, then beq with alu_done two cycles after alu_start
    nonbranch("jmp100", 2'b01, 32'h100, 1'b1, 32'h100);
    chk("jmp100_cnt", 32'(taken_cnt), 32'd1);
    issue(2'b10, 3'b000, 32'h80);
    chk("beq_decode_no_start", 32'(alu_start), 32'd0);
    tick();
    chk("beq_start", 32'(alu_start), 32'd1);
    tick();
    chk("beq_no_restart", 32'(alu_start), 32'd0);
    tick();
    alu_done = 1'b1;
    status = 4'b0001;
    tick();
    alu_done = 1'b0;
    chk("beq_taken", 32'(taken), 32'd1);
    chk("beq_pc_pending", pc, 32'h100);
    tick();
    chk("beq_pc", pc, 32'h80);
    chk("beq_cnt", 32'(taken_cnt), 32'd2);
    chk("beq_taken_end", 32'(taken), 32'd0);

    nonbranch("jmp100b", 2'b01, 32'h100, 1'b1, 32'h100);
    branch("beq_nt", 3'b000, 32'h80, 4'b0000, 1'b0, 32'h104);
    chk("beq_nt_cnt", 32'(taken_cnt), 32'd3);

    // Conditions with N=1, V=0, C=1, Z=0 (status = {V,C,N,Z})
    branch("blt", 3'b100, 32'h200, 4'b0110, 1'b1, 32'h200);
    branch("bge", 3'b101, 32'h400, 4'b0110, 1'b0, 32'h204);
    branch("bltu", 3'b110, 32'h300, 4'b0110, 1'b1, 32'h300);
    branch("bgeu", 3'b111, 32'h400, 4'b0110, 1'b0, 32'h304);
    branch("beq6", 3'b000, 32'h400, 4'b0110, 1'b0, 32'h308);
    branch("bne6", 3'b001, 32'h500, 4'b0110, 1'b1, 32'h500);
    branch("f010", 3'b010, 32'h600, 4'b0001, 1'b0, 32'h504);
    chk("cond_cnt", 32'(taken_cnt), 32'd6);

    // Misaligned jump traps and holds until trap_clr
    issue(2'b01, 3'b000, 32'h102);
    tick();
    chk("trap_no_taken", 32'(taken), 32'd0);
    tick();
    chk("trap_set", 32'(trap), 32'd1);
    chk("trap_pc", pc, 32'h504);
    chk("trap_fetch_req", 32'(fetch_req), 32'd0);
    chk("trap_cnt", 32'(taken_cnt), 32'd6);
    tick();
    chk("trap_held", 32'(trap), 32'd1);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("trap_clr", 32'(trap), 32'd0);
    chk("trap_refetch", 32'(fetch_req), 32'd1);
    chk("trap_refetch_addr", fetch_addr, 32'h504);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("clr_ignored_fetch", 32'(fetch_req), 32'd1);

    // PC wrap and counter saturation on the narrow twin
    nonbranch("jmp_top", 2'b01, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    chk("sat_cnt7", 32'(s_taken_cnt), 32'd7);
    nonbranch("wrap", 2'b11, 32'h0, 1'b0, 32'h0);
    nonbranch("jmp10", 2'b01, 32'h10, 1'b1, 32'h10);
    nonbranch("jmp20", 2'b01, 32'h20, 1'b1, 32'h20);
    chk("cnt9", 32'(taken_cnt), 32'd9);
    chk("sat_hold", 32'(s_taken_cnt), 32'd7);

    // Reset in the middle of a compare
    issue(2'b10, 3'b000, 32'h80);
    tick();
    tick();
    reset = 1'b1;
    alu_done = 1'b1;
    status = 4'b0001;
    tick();
    reset = 1'b0;
    alu_done = 1'b0;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_taken", 32'(taken), 32'd0);
    chk("midrst_cnt", 32'(taken_cnt), 32'd0);
    chk("midrst_fetch_req", 32'(fetch_req), 32'd1);
    tick();
    chk("midrst_taken_later", 32'(taken), 32'd0);
    chk("midrst_pc_later", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
